dmem_arbiter: RTL and testbench

- Shares the single-port data memory between two requesters: the pipeline MEM stage (CPU) and a DMA/program-loader port.
- The CPU has priority. A starvation counter and a bounded burst lock guarantee DMA progress.
- The CPU is stalled only when DMA holds the memory.
- The block sits between the MEM-stage logic and the data memory instance.

---
 rtl/dmem_arbiter.sv | 115 +++++++++++
 tb/tb_dmem_arbiter.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter between the MEM-stage CPU port and a DMA/loader port.
// CPU has priority; a starvation counter and a bounded burst lock keep DMA moving.
module dmem_arbiter #(
  parameter int AW        = 10,
  parameter int DW        = 32,
  parameter int MAX_WAIT  = 4,
  parameter int BURST_MAX = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_stall,
  input  logic          dma_valid,
  input  logic          dma_we,
  input  logic [AW-1:0] dma_addr,
  input  logic [DW-1:0] dma_wdata,
  input  logic          dma_lock,
  output logic          dma_ready,
  output logic [DW-1:0] dma_rdata,
  output logic          dma_rvalid,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wd,
  input  logic [DW-1:0] mem_rd
);

  localparam int WW = $clog2(MAX_WAIT + 1);
  localparam int BW = $clog2(BURST_MAX + 1);

  typedef enum logic {ARB, BURST} state_t;

  state_t        state;
  logic [WW-1:0] wait_cnt;
  logic [BW-1:0] beat_cnt;
  logic [BW-1:0] beat_nxt;
  logic          force_dma;
  logic          grant_dma;
  logic          grant_cpu;

  function automatic logic [WW-1:0] sat_inc(input logic [WW-1:0] v);
    return (v == WW'(MAX_WAIT)) ? v : v + 1'b1;
  endfunction

  // Grant decision: combinational, suppressed entirely while in reset
  always_comb begin
    force_dma = dma_valid && (wait_cnt == WW'(MAX_WAIT));
    grant_dma = 1'b0;
    grant_cpu = 1'b0;
    if (!rst) begin
      if (state == BURST) begin
        grant_dma = dma_valid;
      end else begin
        grant_dma = force_dma || (dma_valid && !cpu_req);
        grant_cpu = cpu_req && !grant_dma;
      end
    end
  end

  assign beat_nxt  = beat_cnt + 1'b1;
  assign dma_ready = grant_dma;
  assign cpu_stall = cpu_req && !grant_cpu && !rst;
  assign mem_we    = grant_dma ? dma_we : (grant_cpu && cpu_we);
  assign mem_addr  = grant_dma ? dma_addr : cpu_addr;
  assign mem_wd    = grant_dma ? dma_wdata : cpu_wdata;
  assign cpu_rdata = mem_rd;

  // State, counters and DMA read-return register
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ARB;
      wait_cnt   <= '0;
      beat_cnt   <= '0;
      dma_rdata  <= '0;
      dma_rvalid <= 1'b0;
    end else begin
      dma_rvalid <= grant_dma && !dma_we;
      if (grant_dma && !dma_we) dma_rdata <= mem_rd;
      case (state)
        ARB: begin
          if (grant_dma) begin
            wait_cnt <= '0;
            if (dma_lock && (BURST_MAX > 1)) begin
              state    <= BURST;
              beat_cnt <= BW'(1);
            end
          end else if (cpu_req) begin
            if (dma_valid) wait_cnt <= sat_inc(wait_cnt);
          end else begin
            wait_cnt <= '0;
          end
        end
        BURST: begin
          if (grant_dma) begin
            // The beat that reaches BURST_MAX hands the next arbitration back to the CPU
            if (!dma_lock || (beat_nxt == BW'(BURST_MAX))) begin
              state    <= ARB;
              beat_cnt <= '0;
            end else begin
              beat_cnt <= beat_nxt;
            end
          end else if (!dma_lock) begin
            state    <= ARB;
            beat_cnt <= '0;
          end
        end
        default: state <= ARB;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: behavioural data memory, per-scenario tasks and a
// DMA read-return scoreboard.
module tb_dmem_arbiter;

  localparam int AW = 10;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          cpu_req, cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata, cpu_rdata;
  logic          cpu_stall;
  logic          dma_valid, dma_we, dma_lock;
  logic [AW-1:0] dma_addr;
  logic [DW-1:0] dma_wdata, dma_rdata;
  logic          dma_ready, dma_rvalid;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wd, mem_rd;

  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [DW-1:0] sb [$];
  int vectors = 0;
  int miscompares = 0;

  dmem_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(4), .BURST_MAX(8)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .dma_valid(dma_valid), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_lock(dma_lock), .dma_ready(dma_ready), .dma_rdata(dma_rdata), .dma_rvalid(dma_rvalid),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  always #5 clk = ~clk;

  assign mem_rd = mem[mem_addr];
  always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wd;

  function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
    return 32'h5A000000 + ({22'b0, a} * 32'h00010001);
  endfunction

  // Scoreboard: every DMA read return must match the oldest expected value
  always @(negedge clk) begin
    if (dma_rvalid === 1'b1) begin
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL rvalid_unexpected: got rdata %h, required no rvalid", dma_rdata);
      end else begin
        logic [DW-1:0] e;
        e = sb.pop_front();
        if (dma_rdata !== e) begin
          miscompares++;
          $display("FAIL dma_rdata: got %h required %h", dma_rdata, e);
        end
      end
    end
  end

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    dma_valid = 0; dma_we = 0; dma_lock = 0; dma_addr = '0; dma_wdata = '0;
  endtask

  task automatic test_reset();
    rst = 1; cpu_req = 1; cpu_we = 1; dma_valid = 1; dma_lock = 1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      vectors++; if (cpu_stall !== 1'b0) begin miscompares++; $display("FAIL reset_stall c%0d: got %b required 0", i, cpu_stall); end
      vectors++; if (dma_ready !== 1'b0) begin miscompares++; $display("FAIL reset_ready c%0d: got %b required 0", i, dma_ready); end
      vectors++; if (mem_we !== 1'b0) begin miscompares++; $display("FAIL reset_we c%0d: got %b required 0", i, mem_we); end
      if (i == 1) begin
        vectors++; if (dma_rvalid !== 1'b0) begin miscompares++; $display("FAIL reset_rvalid: got %b required 0", dma_rvalid); end
      end
      next();
    end
    rst = 0; idle_inputs();
    @(negedge clk);
    vectors++; if ({cpu_stall, dma_ready, mem_we, dma_rvalid} !== 4'b0) begin
      miscompares++; $display("FAIL post_reset_idle: got %b required 0000", {cpu_stall, dma_ready, mem_we, dma_rvalid});
    end
    next();
  endtask

  task automatic test_cpu_only();
    cpu_req = 1; cpu_we = 1; cpu_addr = 10'h010; cpu_wdata = 32'hDEADBEEF;
    @(negedge clk);
    vectors++; if (mem_we !== 1'b1) begin miscompares++; $display("FAIL cpu_write_we: got %b required 1", mem_we); end
    vectors++; if (mem_addr !== 10'h010) begin miscompares++; $display("FAIL cpu_write_addr: got %h required 010", mem_addr); end
    vectors++; if (cpu_stall !== 1'b0) begin miscompares++; $display("FAIL cpu_write_stall: got %b required 0", cpu_stall); end
    next();
    cpu_we = 0;
    @(negedge clk);
    vectors++; if (cpu_rdata !== 32'hDEADBEEF) begin miscompares++; $display("FAIL cpu_read_data: got %h required deadbeef", cpu_rdata); end
    vectors++; if (mem_we !== 1'b0) begin miscompares++; $display("FAIL cpu_read_we: got %b required 0", mem_we); end
    vectors++; if (cpu_stall !== 1'b0) begin miscompares++; $display("FAIL cpu_read_stall: got %b required 0", cpu_stall); end
    next();
    idle_inputs(); next();
  endtask

  task automatic test_starvation();
    cpu_req = 1; cpu_we = 0; cpu_addr = 10'h100;
    dma_valid = 1; dma_we = 0; dma_addr = 10'h020;
    for (int i = 0; i < 6; i++) begin
      logic exp_d;
      exp_d = (i == 4);
      @(negedge clk);
      vectors++; if (dma_ready !== exp_d) begin miscompares++; $display("FAIL starve_ready c%0d: got %b required %b", i, dma_ready, exp_d); end
      vectors++; if (cpu_stall !== exp_d) begin miscompares++; $display("FAIL starve_stall c%0d: got %b required %b", i, cpu_stall, exp_d); end
      if (exp_d) sb.push_back(pat(10'h020));
      if (i == 5) begin
        vectors++; if (dma_rvalid !== 1'b1) begin miscompares++; $display("FAIL starve_rvalid: got %b required 1", dma_rvalid); end
      end
      next();
    end
    idle_inputs(); next();
  endtask

  task automatic test_dma_only();
    dma_valid = 1; dma_we = 1; dma_addr = 10'h3FF; dma_wdata = 32'h12345678;
    @(negedge clk);
    vectors++; if (dma_ready !== 1'b1) begin miscompares++; $display("FAIL dma_only_ready: got %b required 1", dma_ready); end
    vectors++; if (mem_we !== 1'b1 || mem_addr !== 10'h3FF) begin
      miscompares++; $display("FAIL dma_only_mem: got we=%b addr=%h required we=1 addr=3ff", mem_we, mem_addr);
    end
    next();
    idle_inputs();
    @(negedge clk);
    vectors++; if (mem[10'h3FF] !== 32'h12345678) begin miscompares++; $display("FAIL dma_only_stored: got %h required 12345678", mem[10'h3FF]); end
    vectors++; if (dma_rvalid !== 1'b0) begin miscompares++; $display("FAIL dma_only_rvalid: got %b required 0", dma_rvalid); end
    next();
  endtask

  task automatic test_burst();
    int beat;
    beat = 0;
    cpu_req = 1; cpu_we = 1; cpu_addr = 10'h100; cpu_wdata = 32'h0BADF00D;
    dma_valid = 1; dma_we = 0; dma_lock = 1;
    for (int k = 0; k < 18; k++) begin
      logic exp_d;
      exp_d = ((k >= 4) && (k < 12)) || (k >= 16);
      dma_addr = 10'h040 + AW'(beat);
      @(negedge clk);
      vectors++; if (dma_ready !== exp_d) begin miscompares++; $display("FAIL burst_ready c%0d: got %b required %b", k, dma_ready, exp_d); end
      vectors++; if (cpu_stall !== exp_d) begin miscompares++; $display("FAIL burst_stall c%0d: got %b required %b", k, cpu_stall, exp_d); end
      vectors++; if (mem_we !== !exp_d) begin miscompares++; $display("FAIL burst_we c%0d: got %b required %b", k, mem_we, !exp_d); end
      vectors++; if (mem_addr !== (exp_d ? dma_addr : 10'h100)) begin
        miscompares++; $display("FAIL burst_addr c%0d: got %h required %h", k, mem_addr, exp_d ? dma_addr : 10'h100);
      end
      if (exp_d) begin
        sb.push_back(pat(dma_addr));
        beat++;
      end
      next();
    end
    dma_valid = 0; dma_lock = 0;
    @(negedge clk);
    vectors++; if (cpu_stall !== 1'b1 || dma_ready !== 1'b0) begin
      miscompares++; $display("FAIL burst_gap: got stall=%b ready=%b required stall=1 ready=0", cpu_stall, dma_ready);
    end
    next();
    @(negedge clk);
    vectors++; if (cpu_stall !== 1'b0) begin miscompares++; $display("FAIL burst_exit_stall: got %b required 0", cpu_stall); end
    next();
    idle_inputs(); next();
  endtask

  task automatic test_same_addr();
    cpu_req = 1; cpu_we = 0; cpu_addr = 10'h200;
    dma_valid = 1; dma_we = 1; dma_addr = 10'h200; dma_wdata = 32'hAAAA5555;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i < 4) begin
        vectors++; if (cpu_stall !== 1'b0 || cpu_rdata !== pat(10'h200)) begin
          miscompares++; $display("FAIL same_cpu c%0d: got stall=%b rdata=%h required stall=0 rdata=%h", i, cpu_stall, cpu_rdata, pat(10'h200));
        end
      end else begin
        vectors++; if (cpu_stall !== 1'b1 || dma_ready !== 1'b1 || mem_we !== 1'b1) begin
          miscompares++; $display("FAIL same_dma: got stall=%b ready=%b we=%b required 1 1 1", cpu_stall, dma_ready, mem_we);
        end
      end
      next();
    end
    dma_valid = 0;
    @(negedge clk);
    vectors++; if (cpu_stall !== 1'b0 || cpu_rdata !== 32'hAAAA5555) begin
      miscompares++; $display("FAIL same_retry: got stall=%b rdata=%h required stall=0 rdata=aaaa5555", cpu_stall, cpu_rdata);
    end
    next();
    idle_inputs(); next();
  endtask

  task automatic test_reset_mid_burst();
    dma_valid = 1; dma_we = 0; dma_lock = 1; dma_addr = 10'h080;
    @(negedge clk);
    vectors++; if (dma_ready !== 1'b1 || cpu_stall !== 1'b0) begin
      miscompares++; $display("FAIL mid_beat1: got ready=%b stall=%b required 1 0", dma_ready, cpu_stall);
    end
    sb.push_back(pat(10'h080));
    next();
    cpu_req = 1; cpu_we = 1; cpu_addr = 10'h104; cpu_wdata = 32'h00C0FFEE; dma_addr = 10'h081;
    @(negedge clk);
    vectors++; if (dma_ready !== 1'b1 || cpu_stall !== 1'b1 || mem_we !== 1'b0) begin
      miscompares++; $display("FAIL mid_beat2: got ready=%b stall=%b we=%b required 1 1 0", dma_ready, cpu_stall, mem_we);
    end
    sb.push_back(pat(10'h081));
    next();
    rst = 1; dma_addr = 10'h082;
    @(negedge clk);
    vectors++; if (dma_ready !== 1'b0 || cpu_stall !== 1'b0 || mem_we !== 1'b0) begin
      miscompares++; $display("FAIL mid_in_reset: got ready=%b stall=%b we=%b required 0 0 0", dma_ready, cpu_stall, mem_we);
    end
    next();
    rst = 0;
    @(negedge clk);
    vectors++; if (dma_ready !== 1'b0 || cpu_stall !== 1'b0 || mem_we !== 1'b1) begin
      miscompares++; $display("FAIL mid_after_reset: got ready=%b stall=%b we=%b required 0 0 1", dma_ready, cpu_stall, mem_we);
    end
    vectors++; if (dma_rvalid !== 1'b0) begin miscompares++; $display("FAIL mid_rvalid: got %b required 0", dma_rvalid); end
    next();
    idle_inputs(); next();
  endtask

  initial begin
    for (int a = 0; a < (1 << AW); a++) mem[a] = pat(AW'(a));
    idle_inputs();
    rst = 1;
    #1;
    test_reset();
    test_cpu_only();
    test_starvation();
    test_dma_only();
    test_burst();
    test_same_addr();
    test_reset_mid_burst();
    next(); next();
    vectors++; if (sb.size() != 0) begin
      miscompares++; $display("FAIL rvalid_missing: got %0d outstanding reads, required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
